// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider_pkg
// Description : Shared types and constants for the sequential restoring
//               divider: FSM state encoding, default operand width and the
//               iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_restoring_divider_pkg;

    // Default operand/result width
    localparam int DIV_WIDTH = 8;

    // Counter must hold WIDTH-1; $clog2(WIDTH) does for any WIDTH >= 2
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_trial_sub.sv
`default_nettype none
// ============================================================================
// Module      : div_trial_sub
// Description : Combinational W-bit trial subtractor, a - b, built as a
//               ripple chain of full-adder cells on a + ~b + 1.
// Ports       : a         - minuend
//               b         - subtrahend
//               diff      - a - b (modulo 2**W)
//               no_borrow - carry-out; 1 when a >= b
// Revision    : 1.0 - initial release
// ============================================================================
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         no_borrow
);

    logic [W:0] carry;

    // Carry-in of 1 completes the two's-complement negation of b
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_fa
        logic b_inv;
        assign b_inv      = ~b[i];
        assign diff[i]    = a[i] ^ b_inv ^ carry[i];
        assign carry[i+1] = (a[i] & b_inv) | (carry[i] & (a[i] ^ b_inv));
    end

    assign no_borrow = carry[W];

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Iterative unsigned restoring divider, one quotient bit per
//               clock, with a start/busy/done handshake.
// Ports       : clk, rst             - clock, async active-high reset
//               start                - request, sampled only in IDLE
//               dividend, divisor    - operands, captured on accepted start
//               busy                 - high in RUN and DONE
//               done                 - one-cycle pulse, results valid
//               quotient, remainder  - results, held until overwritten
//               div_by_zero          - captured divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // Shift the next dividend bit into the partial remainder
    assign trial = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    div_trial_sub #(
        .W (WIDTH + 1)
    ) u_trial_sub (
        .a         (trial),
        .b         ({1'b0, d_reg}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    // Restore on borrow: keep the shifted value unchanged
    assign r_next = no_borrow ? diff : trial;
    assign q_next = {q_reg[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        r_reg       <= '0;
                        count       <= CNT_W'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        if (divisor == '0) begin
                            // Zero divisor bypasses the iteration entirely
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    count <= count - CNT_W'(1);
                    if (count == '0) begin
                        // Last iteration: publish results straight into the
                        // output registers so they are valid with done
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Self-checking bench for seq_restoring_divider (WIDTH=8):
//               directed vector table, reset/handshake sequences and a
//               randomized invariant sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Issue one start; returns edges from the start edge until done is seen
    // (0 = done right after the start edge), plus busy-high cycle count.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int bcnt, output bit got);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        got  = done;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
            got = done;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int  lat;
        int  bcnt;
        bit  got;
        int  done_seen;
        int  last_edge;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   dz: 1'b0, lat: W};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0, lat: W};
        vecs[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0, lat: W};
        vecs[3] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0, lat: W};
        vecs[4] = '{a: 8'd0,   b: 8'd13,  q: 8'd0,   r: 8'd0,   dz: 1'b0, lat: W};
        vecs[5] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, dz: 1'b1, lat: 0};
        vecs[6] = '{a: 8'd100, b: 8'd3,   q: 8'd33,  r: 8'd1,   dz: 1'b0, lat: W};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation must abort asynchronously
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midreset_busy_async", busy, 0);
        chk("midreset_quotient", quotient, 0);
        chk("midreset_remainder", remainder, 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("midreset_no_done", done_seen, 0);

        // Directed table
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, lat, bcnt, got);
            chk($sformatf("v%0d_done", i), got, 1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            chk($sformatf("v%0d_dz", i), div_by_zero, vecs[i].dz);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat + 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // Start held high: back-to-back 50/6, one division per W+2 edges
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd6;
        start    = 1'b1;
        done_seen = 0;
        last_edge = -1;
        for (int e = 0; e < 3 * (W + 2) + 2; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("b2b_quotient", quotient, 8);
                chk("b2b_remainder", remainder, 2);
                if (last_edge >= 0) chk("b2b_period", e - last_edge, W + 2);
                last_edge = e;
                done_seen++;
            end
        end
        chk("b2b_done_count", done_seen, 3);
        @(negedge clk);
        start = 1'b0;
        repeat (W + 3) @(posedge clk);

        // Start pulses and operand changes during RUN are ignored
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            start    = ~start;
            @(posedge clk);
            #1;
            lat++;
            got = done;
        end
        start = 1'b0;
        chk("abuse_latency", lat, W);
        chk("abuse_quotient", quotient, 28);
        chk("abuse_remainder", remainder, 4);
        repeat (2) @(posedge clk);

        // Randomized invariant sweep
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_div(ra, rb, lat, bcnt, got);
            if (rb == 0) begin
                chk("rnd_dz_q", quotient, 255);
                chk("rnd_dz_r", remainder, ra);
                chk("rnd_dz_flag", div_by_zero, 1);
            end else begin
                chk("rnd_invariant", quotient * rb + remainder, ra);
                chk("rnd_rem_lt", remainder < rb, 1);
                chk("rnd_dz_flag", div_by_zero, 0);
            end
            @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
